// File: rtl/i2s_clk_ctrl.sv
// I2S master timing: divides clk into bck/lrck and emits per-bit strobes, slot position and frame count.
// Latency: running rises one clk after enable is sampled; every output is a flop, updated on each clk edge.
// No backpressure: enable low stops only at the end of a frame, so every frame is complete.
module i2s_clk_ctrl #(
  parameter int WORD_SIZE = 24,
  parameter int SLOT_BITS = 32,
  parameter int DIV_W     = 8,
  parameter int FCNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [DIV_W-1:0]             div,
  output logic                         bck,
  output logic                         lrck,
  output logic                         running,
  output logic                         bit_strobe,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
  output logic                         chan,
  output logic                         data_bit,
  output logic                         word_done,
  output logic [FCNT_W-1:0]            frame_cnt
);

  localparam int IDX_W = $clog2(SLOT_BITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic              bck_q;
  logic              lrck_q;
  logic              running_q;
  logic              bit_strobe_q;
  logic              data_bit_q;
  logic              word_done_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [FCNT_W-1:0] frame_cnt_q;

  logic active;
  logic tick;
  logic rise;
  logic fall;
  logic wrap;
  logic frame_end;
  logic in_word;

  // Edge decode: tick marks a bck half-period boundary; wrap/frame_end mark slot and frame ends
  always_comb begin
    active    = (state_q != S_IDLE);
    tick      = active && (div_cnt_q == div_q);
    rise      = tick && !bck_q;
    fall      = tick && bck_q;
    wrap      = fall && (bit_idx_q == IDX_W'(SLOT_BITS - 1));
    frame_end = wrap && lrck_q;
    in_word   = (bit_idx_q != '0) && (bit_idx_q <= IDX_W'(WORD_SIZE));
  end

  // Control FSM with the divider, slot position, strobes and frame counter all registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      div_cnt_q    <= '0;
      bck_q        <= 1'b0;
      lrck_q       <= 1'b0;
      running_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
      data_bit_q   <= 1'b0;
      word_done_q  <= 1'b0;
      bit_idx_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      bit_strobe_q <= 1'b0;
      data_bit_q   <= 1'b0;
      word_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // div is captured only here, so mid-run changes wait for the next start
          if (enable) begin
            div_q     <= div;
            div_cnt_q <= '0;
            running_q <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        default: begin
          if (tick) begin
            div_cnt_q <= '0;
            bck_q     <= ~bck_q;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
          // Sample point: bit_idx/chan are stable through the whole high phase
          if (rise) begin
            bit_strobe_q <= 1'b1;
            data_bit_q   <= in_word;
            word_done_q  <= (bit_idx_q == IDX_W'(WORD_SIZE));
          end
          // Position advances on the falling edge; lrck flips with the slot wrap
          if (fall) begin
            if (wrap) begin
              bit_idx_q <= '0;
              lrck_q    <= ~lrck_q;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
          if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
          end
          // A stop request retires only on a frame end; re-enabling cancels it seamlessly
          if (enable) begin
            state_q <= S_RUN;
          end else if (state_q == S_STOP && frame_end) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
            bck_q     <= 1'b0;
            lrck_q    <= 1'b0;
            bit_idx_q <= '0;
            div_cnt_q <= '0;
          end else begin
            state_q <= S_STOP;
          end
        end
      endcase
    end
  end

  assign bck        = bck_q;
  assign lrck       = lrck_q;
  assign chan       = lrck_q;
  assign running    = running_q;
  assign bit_strobe = bit_strobe_q;
  assign bit_idx    = bit_idx_q;
  assign data_bit   = data_bit_q;
  assign word_done  = word_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
